// File: rtl/clk_divider_pkg.sv
// Shared constants and helpers for the programmable sck divider.
package clk_divider_pkg;

   localparam int DIV_WIDTH_DEF = 24;
   localparam int MIN_DIV       = 2;

   // Low phase gets the extra cycle on odd divisors.
   function automatic logic [31:0] low_len(input logic [31:0] d);
      return d - (d >> 1);
   endfunction

endpackage

// File: rtl/clk_divider_cnt.sv
// Enable-gated 0..D-1 wrap counter; exposes its next value and the wrap strobe.
module clk_divider_cnt
   import clk_divider_pkg::*;
#(
   parameter int W = DIV_WIDTH_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] div_i,
   output logic [W-1:0] cnt_nxt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      wrap_o = en_i && (cnt_q == div_i - W'(1));
      cnt_d  = cnt_q;
      if (wrap_o)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/clk_divider.sv
// Programmable glitch-free clock divider with clk-domain edge strobes and
// period-boundary divisor reload.
module clk_divider
   import clk_divider_pkg::*;
#(
   parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
   parameter int DEFAULT_DIV = 27000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div_val,
   input  logic                 div_load,
   output logic                 sck,
   output logic                 sck_rise,
   output logic                 sck_fall,
   output logic                 busy
);

   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] pend_q, pend_d;
   logic                 busy_q, busy_d;
   logic                 sck_q, sck_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic [DIV_WIDTH-1:0] div_clamp;
   logic [DIV_WIDTH-1:0] lo_len;
   logic [DIV_WIDTH-1:0] cnt_nxt;
   logic                 wrap;

   clk_divider_cnt #(.W(DIV_WIDTH)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .div_i     (div_q),
      .cnt_nxt_o (cnt_nxt),
      .wrap_o    (wrap)
   );

   assign div_clamp = (div_val < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : div_val;
   assign lo_len    = DIV_WIDTH'(low_len(32'(div_q)));

   always_comb begin
      div_d  = div_q;
      pend_d = pend_q;
      busy_d = busy_q;
      // A pending divisor swaps in at the wrap; a load in the same cycle
      // refills the pending slot and waits for the following wrap.
      if (wrap && busy_q) begin
         div_d  = pend_q;
         busy_d = 1'b0;
      end
      if (div_load) begin
         pend_d = div_clamp;
         busy_d = 1'b1;
      end
   end

   // At a wrap cnt_nxt is 0, so the old divisor's low length is safe to use.
   always_comb begin
      sck_d  = (cnt_nxt >= lo_len);
      rise_d = en && (cnt_nxt == lo_len);
      fall_d = wrap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= DIV_WIDTH'(DEFAULT_DIV);
         pend_q <= '0;
         busy_q <= 1'b0;
         sck_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
         sck_q  <= sck_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sck      = sck_q;
   assign sck_rise = rise_q;
   assign sck_fall = fall_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_clk_divider.sv
// Scoreboard bench for clk_divider: a cycle model pushes expected outputs as
// stimulus is driven; a monitor pops and compares after each posedge.
module tb_clk_divider;

   localparam int DW = 24;
   localparam int DEF = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic [DW-1:0] div_val = '0;
   logic          div_load = 1'b0;
   logic          sck, sck_rise, sck_fall, busy;

   clk_divider #(.DIV_WIDTH(DW), .DEFAULT_DIV(DEF)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .div_val  (div_val),
      .div_load (div_load),
      .sck      (sck),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       cyc;
      logic [3:0] v;   // {sck, rise, fall, busy}
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // model state: what the DUT holds after the most recent posedge
   int   m_cnt, m_d, m_pend;
   logic m_busy, m_sck;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_cnt = 0; m_d = DEF; m_pend = 0; m_busy = 1'b0; m_sck = 1'b0;
   endtask

   // Drive one cycle of stimulus and push what the outputs must be after it.
   task automatic step(input logic e, input logic ld, input int val);
      exp_t x;
      logic wr, rs;
      int   lo;
      @(negedge clk);
      en = e; div_load = ld; div_val = DW'(val);
      wr = e && (m_cnt == m_d - 1);
      if (e) m_cnt = wr ? 0 : m_cnt + 1;
      if (wr && m_busy) begin m_d = m_pend; m_busy = 1'b0; end
      if (ld) begin m_pend = (val < 2) ? 2 : val; m_busy = 1'b1; end
      lo = m_d - m_d / 2;
      m_sck = (m_cnt >= lo);
      rs = e && (m_cnt == lo);
      cyc++;
      x.cyc = cyc;
      x.v = {m_sck, rs, wr, m_busy};
      sb.push_back(x);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #2;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("wave@%0d", e.cyc), {sck, sck_rise, sck_fall, busy}, e.v);
      end
   end

   initial begin
      logic [3:0] pat;
      int k;
      m_reset();
      #1;
      chk("rst_out", {sck, sck_rise, sck_fall, busy}, 4'b0000);
      @(negedge clk); rst = 1'b0;

      // D=4 from reset: literal 0,0,1,1 pattern alongside the model
      pat = 4'b1100;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 0);
         @(posedge clk); #3;
         chk($sformatf("pat4_%0d", i), sck, pat[(i + 1) % 4]);
      end

      // load 5 mid-period
      run(1);
      step(1'b1, 1'b1, 5);
      run(16);

      // clamp: 1 -> 2, then 7, then 0 -> 2
      step(1'b1, 1'b1, 1); run(12);
      step(1'b1, 1'b1, 7); run(16);
      step(1'b1, 1'b1, 0); run(12);

      // freeze mid-high phase with D=6
      step(1'b1, 1'b1, 6); run(8);
      k = 0;
      while (!(m_cnt == 4 && m_d == 6) && k < 20) begin step(1'b1, 1'b0, 0); k++; end
      chk("reach_high", k < 20, 1);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0);
      run(14);

      // last-wins double load
      step(1'b1, 1'b1, 6); step(1'b1, 1'b1, 8); run(24);

      // load coincident with the wrap
      k = 0;
      while (m_cnt != m_d - 2 && k < 20) begin step(1'b1, 1'b0, 0); k++; end
      chk("reach_wrap", k < 20, 1);
      step(1'b1, 1'b1, 3); // this step lands cnt on D-1
      step(1'b1, 1'b1, 5); // wrap cycle: 3 applies now, 5 waits
      run(20);

      // random traffic
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), int'($urandom_range(0, 9)));

      // async reset while sck high and busy
      step(1'b1, 1'b1, 9);
      k = 0;
      while (!(m_sck && m_busy) && k < 40) begin step(1'b1, 1'b0, 0); k++; end
      chk("reach_hibusy", k < 40, 1);
      @(posedge clk); #3;
      chk("pre_rst", {sck, busy}, 2'b11);
      en = 1'b0; div_load = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_rst", {sck, sck_rise, sck_fall, busy}, 4'b0000);
      @(negedge clk); rst = 1'b0;
      m_reset();
      run(12);

      @(negedge clk); @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_divider.md
Name: clk_divider

Overview:
Programmable integer clock divider that derives a slow serial clock `sck` from the system clock `clk`. It drives the bit clock of the serial debug/logic-analyser path (sda/sck) in the blink/sigrok top level. `sck` is a registered, glitch-free output. One-cycle `clk`-domain strobes mark its edges, so logic in the `clk` domain can align to `sck` without sampling it.

Parameters:
DIV_WIDTH, 24, width of the divisor and the internal counter.
DEFAULT_DIV, 27000, divisor loaded at reset (27 MHz -> 1 kHz).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable; tie high for free-running operation.
div_val  input  DIV_WIDTH  requested divisor (sck period, in clk cycles).
div_load  input  1  single-cycle request to adopt div_val.
sck  output  1  divided clock.
sck_rise  output  1  one-clk strobe, high in the first clk cycle that sck is high.
sck_fall  output  1  one-clk strobe, high in the first clk cycle that sck is low.
busy  output  1  high while a divisor load is pending and not yet applied.

Behaviour:
Reset, asynchronous, applied immediately:
- cnt = 0, sck = 0, sck_rise = 0, sck_fall = 0, busy = 0.
- Active divisor D = DEFAULT_DIV; pending register cleared.

Waveform (D >= 2):
- Period = D clk cycles.
- Low phase = L = ceil(D/2) cycles; high phase = H = floor(D/2) cycles.
- cnt runs 0..D-1 and advances by 1 on each posedge clk with en = 1.
- cnt wraps to 0 after D-1.
- sck is registered: sck = 1 exactly when cnt is in L..D-1.
- After reset release with en = 1: sck low for L cycles, then high for H cycles, repeating.

Strobes:
- sck_rise: asserted in the cycle where cnt == L.
- sck_fall: asserted in the cycle where cnt == 0 after a wrap; not asserted in the first period after reset.
- Both strobes are registered with sck, so they coincide with the sck edge.

Enable:
- en = 0 freezes cnt and sck at their current values.
- Strobes are forced to 0 while frozen.
- Resuming continues the phase with no glitch.

Divisor load:
- div_load = 1 captures div_val into the pending register and sets busy = 1.
- div_val < 2 is clamped to 2; div_val = 0 is also clamped to 2.
- Pending D takes effect only at a period boundary (cnt wraps D-1 -> 0); busy clears in that same cycle.
- The current period always completes with the old D, so no runt pulses.
- A second div_load while busy overwrites the pending value (last wins).
- div_load in the same cycle as the wrap: the new value applies at the next wrap, not this one.

D = 2 case: sck toggles every clk cycle (L = H = 1).

Arithmetic:
- Unsigned throughout.
- L is computed as D - (D >> 1).
- No overflow: cnt < D <= 2^DIV_WIDTH - 1.

Reset mid-operation:
- Output returns to 0 immediately (asynchronous).
- Any pending load is discarded.

Decomposition:
- Package clk_divider_pkg holds:
  - MIN_DIV = 2.
  - DIV_WIDTH default.
  - A helper function low_len(D) = D - (D >> 1).
- One natural sub-module, clk_divider_cnt: the enable-gated wrap counter with terminal-count output.
- Top level holds the divisor shadow/pending registers, the sck/strobe registers and the clamp.

Test Plan:
- Reset with DEFAULT_DIV = 4, en = 1 -> sck pattern 0,0,1,1 repeating. sck_rise at cycles 2, 6, ... sck_fall at cycles 4, 8, ...
- Load div_val = 5 mid-period while D = 4 -> busy high until the next wrap. Then sck = 0,0,0,1,1 repeating (L = 3, H = 2). No period shorter than 4 cycles appears before the switch.
- Load div_val = 1, then separately div_val = 0 -> each clamps to D = 2. sck toggles every cycle, and sck_rise/sck_fall alternate every cycle.
- en dropped for 7 cycles while sck = 1 mid-high phase -> sck holds 1, strobes 0. On resume the remaining high cycles complete with the correct count.
- Assert rst while sck = 1 and busy = 1 -> sck, strobes and busy go 0 without waiting for a clk edge. After release D = DEFAULT_DIV.
- Two div_load pulses (6, then 8) before the wrap -> D = 8 applied at the wrap; D = 6 never appears.
